time_set_ctrl: RTL and testbench

//  Time-setting sequencer for the clock's current-time counter. Debounced button events move it

---
 rtl/time_set_ctrl.sv | 144 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Purpose  : Button-driven hours/minutes/seconds edit sequencer with one-cycle LOAD.
// Revision : 1.0
// ============================================================================
module time_set_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int TO_W    = 5
) (
  input  logic       slowclk,
  input  logic       reset,
  input  logic       MODE_BTN,
  input  logic       INC_BTN,
  input  logic       DEC_BTN,
  input  logic [4:0] H_CUR,
  input  logic [5:0] M_CUR,
  input  logic [5:0] S_CUR,
  output logic [4:0] H_SET,
  output logic [5:0] M_SET,
  output logic [5:0] S_SET,
  output logic       LOAD,
  output logic       SET_ACTIVE,
  output logic [1:0] FIELD
);

  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] SET_H  = 3'd1;
  localparam logic [2:0] SET_M  = 3'd2;
  localparam logic [2:0] SET_S  = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  logic [2:0]      sync1, sync2, prev;
  logic [2:0]      evt;
  logic            mode_ev, inc_ev, dec_ev, any_ev;
  logic [2:0]      state, state_nx;
  logic [TO_W-1:0] to_cnt, to_nx;
  logic [4:0]      h_nx;
  logic [5:0]      m_nx, s_nx;
  logic [1:0]      field_nx;

  function automatic logic [4:0] hr_step(input logic [4:0] v, input logic up);
    if (up) hr_step = (v == 5'd23) ? 5'd0 : v + 5'd1;
    else    hr_step = (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] ms_step(input logic [5:0] v, input logic up);
    if (up) ms_step = (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    ms_step = (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  // Sync/prev flops reset high so a button held through reset yields no event.
  always_ff @(posedge slowclk or posedge reset) begin
    if (reset) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      prev  <= 3'b111;
    end else begin
      sync1 <= {MODE_BTN, INC_BTN, DEC_BTN};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign evt     = sync2 & ~prev;
  assign mode_ev = evt[2];
  assign inc_ev  = evt[1] & ~evt[0];
  assign dec_ev  = evt[0] & ~evt[1];
  assign any_ev  = |evt;

  always_comb begin
    state_nx = state;
    to_nx    = to_cnt;
    h_nx     = H_SET;
    m_nx     = M_SET;
    s_nx     = S_SET;
    case (state)
      RUN: begin
        if (mode_ev) begin
          state_nx = SET_H;
          to_nx    = '0;
          h_nx     = (H_CUR > 5'd23) ? 5'd0 : H_CUR;
          m_nx     = (M_CUR > 6'd59) ? 6'd0 : M_CUR;
          s_nx     = (S_CUR > 6'd59) ? 6'd0 : S_CUR;
        end
      end
      SET_H, SET_M, SET_S: begin
        if (mode_ev) begin
          // MODE beats any coincident INC/DEC.
          state_nx = (state == SET_H) ? SET_M : (state == SET_M) ? SET_S : COMMIT;
          to_nx    = '0;
        end else if (any_ev) begin
          to_nx = '0;
          if (inc_ev || dec_ev) begin
            if (state == SET_H)      h_nx = hr_step(H_SET, inc_ev);
            else if (state == SET_M) m_nx = ms_step(M_SET, inc_ev);
            else                     s_nx = ms_step(S_SET, inc_ev);
          end
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          state_nx = RUN;
          to_nx    = '0;
        end else begin
          to_nx = to_cnt + 1'b1;
        end
      end
      COMMIT:  state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    field_nx = 2'b00;
    case (state_nx)
      SET_H:   field_nx = 2'b01;
      SET_M:   field_nx = 2'b10;
      SET_S:   field_nx = 2'b11;
      default: field_nx = 2'b00;
    endcase
  end

  always_ff @(posedge slowclk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      to_cnt     <= '0;
      H_SET      <= '0;
      M_SET      <= '0;
      S_SET      <= '0;
      LOAD       <= 1'b0;
      SET_ACTIVE <= 1'b0;
      FIELD      <= 2'b00;
    end else begin
      state      <= state_nx;
      to_cnt     <= to_nx;
      H_SET      <= h_nx;
      M_SET      <= m_nx;
      S_SET      <= s_nx;
      LOAD       <= (state_nx == COMMIT);
      SET_ACTIVE <= (state_nx != RUN);
      FIELD      <= field_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_set_ctrl
// Purpose  : Directed self-checking bench for time_set_ctrl.
// Revision : 1.0
// ============================================================================
module tb_time_set_ctrl;

  logic       slowclk = 1'b0;
  logic       reset   = 1'b1;
  logic       MODE_BTN = 1'b0, INC_BTN = 1'b0, DEC_BTN = 1'b0;
  logic [4:0] H_CUR = '0;
  logic [5:0] M_CUR = '0, S_CUR = '0;
  logic [4:0] H_SET;
  logic [5:0] M_SET, S_SET;
  logic       LOAD, SET_ACTIVE;
  logic [1:0] FIELD;

  int tests = 0;
  int fails = 0;
  int load_cycles = 0;

  time_set_ctrl #(.TIMEOUT(30), .TO_W(5)) dut (
    .slowclk(slowclk), .reset(reset),
    .MODE_BTN(MODE_BTN), .INC_BTN(INC_BTN), .DEC_BTN(DEC_BTN),
    .H_CUR(H_CUR), .M_CUR(M_CUR), .S_CUR(S_CUR),
    .H_SET(H_SET), .M_SET(M_SET), .S_SET(S_SET),
    .LOAD(LOAD), .SET_ACTIVE(SET_ACTIVE), .FIELD(FIELD)
  );

  always #5 slowclk = ~slowclk;

  always @(negedge slowclk) if (LOAD === 1'b1) load_cycles++;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_vals(input string tag, input int h, input int m, input int s);
    check({tag, " H"}, int'(H_SET), h);
    check({tag, " M"}, int'(M_SET), m);
    check({tag, " S"}, int'(S_SET), s);
  endtask

  // Effect lands on the 3rd edge; returns #1 after effect edge + 2 release edges.
  task automatic press(input logic m, input logic i, input logic d);
    @(negedge slowclk);
    MODE_BTN = m; INC_BTN = i; DEC_BTN = d;
    repeat (3) @(posedge slowclk);
    #1;
    MODE_BTN = 1'b0; INC_BTN = 1'b0; DEC_BTN = 1'b0;
    repeat (2) @(posedge slowclk);
    #1;
  endtask

  initial begin
    // ---- Test 1: reset and full edit/commit sequence
    H_CUR = 5'd9; M_CUR = 6'd16; S_CUR = 6'd22;
    repeat (3) @(posedge slowclk);
    #1;
    check_vals("reset", 0, 0, 0);
    check("reset LOAD", int'(LOAD), 0);
    check("reset ACTIVE", int'(SET_ACTIVE), 0);
    check("reset FIELD", int'(FIELD), 0);
    @(negedge slowclk);
    reset = 1'b0;
    repeat (3) @(posedge slowclk);
    #1;
    check("idle FIELD", int'(FIELD), 0);

    press(1, 0, 0);
    check("enter FIELD", int'(FIELD), 1);
    check("enter ACTIVE", int'(SET_ACTIVE), 1);
    check_vals("snapshot", 9, 16, 22);
    repeat (2) press(0, 1, 0);
    check("inc2 H", int'(H_SET), 11);
    press(1, 0, 0);
    check("SET_M FIELD", int'(FIELD), 2);
    repeat (17) press(0, 0, 1);
    check_vals("dec17", 11, 59, 22);
    press(1, 0, 0);
    check("SET_S FIELD", int'(FIELD), 3);
    @(negedge slowclk);
    MODE_BTN = 1'b1;
    repeat (3) @(posedge slowclk);
    #1;
    MODE_BTN = 1'b0;
    check("commit LOAD", int'(LOAD), 1);
    check("commit ACTIVE", int'(SET_ACTIVE), 1);
    check("commit FIELD", int'(FIELD), 0);
    check_vals("commit", 11, 59, 22);
    @(posedge slowclk);
    #1;
    check("post LOAD", int'(LOAD), 0);
    check("post ACTIVE", int'(SET_ACTIVE), 0);
    check_vals("post hold", 11, 59, 22);
    check("load count t1", load_cycles, 1);
    repeat (2) @(posedge slowclk);

    // ---- Test 2: wraps, then timeout out of SET_S holds values
    H_CUR = 5'd23; M_CUR = 6'd0; S_CUR = 6'd59;
    press(1, 0, 0);
    check_vals("snap2", 23, 0, 59);
    press(0, 1, 0);
    check("H 23+1", int'(H_SET), 0);
    press(0, 0, 1);
    check("H 0-1", int'(H_SET), 23);
    press(1, 0, 0);
    press(0, 0, 1);
    check("M 0-1", int'(M_SET), 59);
    press(1, 0, 0);
    press(0, 1, 0);
    check("S 59+1", int'(S_SET), 0);
    repeat (27) @(posedge slowclk);
    #1;
    check("S to 29", int'(SET_ACTIVE), 1);
    @(posedge slowclk);
    #1;
    check("S to 30", int'(SET_ACTIVE), 0);
    check("S to FIELD", int'(FIELD), 0);
    check_vals("to hold", 23, 59, 0);
    check("load count t2", load_cycles, 1);

    // ---- Test 3: exact timeout from SET_H and restart at cycle 29
    H_CUR = 5'd1; M_CUR = 6'd2; S_CUR = 6'd3;
    press(1, 0, 0);
    repeat (27) @(posedge slowclk);
    #1;
    check("H to 29", int'(SET_ACTIVE), 1);
    @(posedge slowclk);
    #1;
    check("H to 30", int'(SET_ACTIVE), 0);
    press(1, 0, 0);
    repeat (24) @(posedge slowclk);
    press(0, 1, 0);
    check("restart H", int'(H_SET), 2);
    repeat (27) @(posedge slowclk);
    #1;
    check("restart 29", int'(SET_ACTIVE), 1);
    @(posedge slowclk);
    #1;
    check("restart 30", int'(SET_ACTIVE), 0);
    check("load count t3", load_cycles, 1);

    // ---- Test 6: snapshot clamp
    H_CUR = 5'd27; M_CUR = 6'd63; S_CUR = 6'd45;
    press(1, 0, 0);
    check_vals("clamp", 0, 0, 45);

    // ---- Test 4: simultaneous events
    press(1, 1, 0);
    check("MODE+INC FIELD", int'(FIELD), 2);
    check("MODE+INC H", int'(H_SET), 0);
    press(0, 1, 0);
    press(0, 1, 1);
    check("INC+DEC M", int'(M_SET), 1);
    check("INC+DEC FIELD", int'(FIELD), 2);

    // ---- Test 5: async reset mid-SET_M, MODE held across release
    @(negedge slowclk);
    #2;
    reset = 1'b1;
    #1;
    check("async ACTIVE", int'(SET_ACTIVE), 0);
    check("async FIELD", int'(FIELD), 0);
    check_vals("async", 0, 0, 0);
    MODE_BTN = 1'b1;
    repeat (2) @(posedge slowclk);
    @(negedge slowclk);
    reset = 1'b0;
    repeat (6) @(posedge slowclk);
    #1;
    check("held MODE", int'(SET_ACTIVE), 0);
    MODE_BTN = 1'b0;
    repeat (3) @(posedge slowclk);
    #1;
    check("release MODE", int'(SET_ACTIVE), 0);
    H_CUR = 5'd4; M_CUR = 6'd5; S_CUR = 6'd6;
    press(1, 0, 0);
    check("repress FIELD", int'(FIELD), 1);
    check_vals("repress", 4, 5, 6);
    check("load count end", load_cycles, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
